// File: rtl/wb_pkg.sv
// Shared defaults, drain-FSM encoding and address slicing for the store write buffer.
package wb_pkg;

    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned DefaultAw    = 32;

    // Loads and stores match on the word address, so the byte offset is dropped.
    localparam int unsigned ByteOffW = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/write_buffer_if.sv
// Pipeline-side store/load ports and memory-side drain ports of the write buffer.
interface write_buffer_if
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = DefaultAw
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            st_valid;
    logic [AW-1:0]   st_addr;
    logic [AW-1:0]   st_data;
    logic            st_ready;
    logic            ld_valid;
    logic [AW-1:0]   ld_addr;
    logic            fwd_hit;
    logic [AW-1:0]   fwd_data;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic [AW-1:0]   mem_data;
    logic            mem_ack;
    logic [CntW-1:0] count;
    logic            empty;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        input  st_ready, fwd_hit, fwd_data, mem_req, mem_addr, mem_data, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        output st_ready, fwd_hit, fwd_data, mem_req, mem_addr, mem_data, count, empty
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Combinational youngest-match search over the occupied write-buffer entries.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = DefaultAw
) (
    input  logic [DEPTH-1:0]          occ_i,
    input  logic [DEPTH-1:0][AW-1:0]  addr_i,
    input  logic [DEPTH-1:0][AW-1:0]  data_i,
    input  logic [$clog2(DEPTH)-1:0]  rd_ptr_i,
    input  logic [$clog2(DEPTH)-1:0]  wr_ptr_i,
    input  logic [AW-1:0]             ld_addr_i,
    output logic                      hit_o,
    output logic [AW-1:0]             data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] idx;

    // Walk from oldest to youngest (backwards from wr_ptr) so the youngest match overwrites.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr_i - PtrW'(k + 1);
            if (occ_i[idx] && (addr_i[idx][AW-1:ByteOffW] == ld_addr_i[AW-1:ByteOffW])) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

    // rd_ptr is already folded into occ_i; byte offsets never take part in the match.
    logic unused_bits;
    always_comb begin
        unused_bits = ^{rd_ptr_i, ld_addr_i[ByteOffW-1:0]};
        for (int i = 0; i < DEPTH; i++) begin
            unused_bits = unused_bits ^ (^addr_i[i][ByteOffW-1:0]);
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Store write buffer: circular FIFO of {addr, data}, in-order drain FSM and load forwarding.
module write_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = DefaultAw
) (
    input logic           CLK,
    input logic           RST,
    write_buffer_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_state_e                state_q, state_d;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][AW-1:0] data_q;

    logic                     st_ready;
    logic                     push;
    logic                     pop;
    logic                     has_entry;
    logic [DEPTH-1:0]         occ;
    logic [PtrW-1:0]          age;
    logic                     match_hit;
    logic [AW-1:0]            match_data;
    logic                     fwd_hit;

    // Readiness uses the registered count only, so a same-cycle pop never frees a slot.
    assign st_ready  = count_q < CntW'(DEPTH);
    assign push      = bus.st_valid && st_ready;
    assign pop       = (state_q == StReq) && bus.mem_ack;
    assign has_entry = count_q != '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (has_entry) state_d = StReq;
            StReq:  if (bus.mem_ack) state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            addr_q[wr_ptr_q] <= bus.st_addr;
            data_q[wr_ptr_q] <= bus.st_data;
        end
    end

    // An entry is live when its distance from the head is below the occupancy count.
    always_comb begin
        occ = '0;
        age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age    = PtrW'(i) - rd_ptr_q;
            occ[i] = {1'b0, age} < count_q;
        end
    end

    wb_fwd_match #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fwd_match (
        .occ_i    (occ),
        .addr_i   (addr_q),
        .data_i   (data_q),
        .rd_ptr_i (rd_ptr_q),
        .wr_ptr_i (wr_ptr_q),
        .ld_addr_i(bus.ld_addr),
        .hit_o    (match_hit),
        .data_o   (match_data)
    );

    assign fwd_hit      = bus.ld_valid && match_hit;
    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_hit ? match_data : '0;

    assign bus.st_ready = st_ready;
    assign bus.count    = count_q;
    assign bus.empty    = !has_entry;
    assign bus.mem_req  = state_q == StReq;
    assign bus.mem_addr = has_entry ? addr_q[rd_ptr_q] : '0;
    assign bus.mem_data = has_entry ? data_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: vector table plus multi-cycle drain/fill/reset sequences.
module tb_write_buffer;

    localparam int unsigned Depth = 4;
    localparam int unsigned Aw    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    write_buffer_if #(.DEPTH(Depth), .AW(Aw)) bus ();

    write_buffer #(
        .DEPTH(Depth),
        .AW   (Aw)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic        mem_ack;
        logic        e_ready;
        logic        e_hit;
        logic [31:0] e_fdata;
        logic        e_req;
        logic [31:0] e_maddr;
        logic [31:0] e_mdata;
        logic [31:0] e_count;
        logic        e_empty;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        tick();
        bus.st_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag, output logic ok);
        int waited = 0;
        while (!bus.mem_req && waited < 20) begin
            tick();
            waited++;
        end
        ok = bus.mem_req;
        if (!ok) chk({tag, "_req_timeout"}, 32'(bus.mem_req), 32'd1);
    endtask

    task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        logic ok;
        wait_req(tag, ok);
        if (ok) begin
            chk({tag, "_addr"}, bus.mem_addr, ea);
            chk({tag, "_data"}, bus.mem_data, ed);
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic ok;

        // st_v addr data ld_v ld_addr ack | rdy hit fdata req maddr mdata count empty
        vecs[0]  = '{1'b1, 32'h20, 32'h7, 1'b0, 32'h00, 1'b0,
                     1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0, 32'd0, 1'b1};
        vecs[1]  = '{1'b1, 32'h20, 32'h9, 1'b1, 32'h22, 1'b0,
                     1'b1, 1'b1, 32'h7, 1'b0, 32'h00, 32'h0, 32'd1, 1'b0};
        vecs[2]  = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h22, 1'b0,
                     1'b1, 1'b1, 32'h9, 1'b1, 32'h20, 32'h7, 32'd2, 1'b0};
        vecs[3]  = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h24, 1'b0,
                     1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h7, 32'd2, 1'b0};
        vecs[4]  = '{1'b0, 32'h00, 32'h0, 1'b0, 32'h20, 1'b0,
                     1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h7, 32'd2, 1'b0};
        vecs[5]  = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h20, 1'b1,
                     1'b1, 1'b1, 32'h9, 1'b1, 32'h20, 32'h7, 32'd2, 1'b0};
        vecs[6]  = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h20, 1'b1,
                     1'b1, 1'b1, 32'h9, 1'b0, 32'h00, 32'h0, 32'd1, 1'b0};
        vecs[7]  = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h20, 1'b0,
                     1'b1, 1'b1, 32'h9, 1'b1, 32'h20, 32'h9, 32'd1, 1'b0};
        vecs[8]  = '{1'b1, 32'h30, 32'h3, 1'b0, 32'h00, 1'b1,
                     1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h9, 32'd1, 1'b0};
        vecs[9]  = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h20, 1'b0,
                     1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0, 32'd1, 1'b0};
        vecs[10] = '{1'b0, 32'h00, 32'h0, 1'b1, 32'h30, 1'b1,
                     1'b1, 1'b1, 32'h3, 1'b1, 32'h30, 32'h3, 32'd1, 1'b0};
        vecs[11] = '{1'b0, 32'h00, 32'h0, 1'b0, 32'h00, 1'b0,
                     1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0, 32'd0, 1'b1};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_hit", 32'(bus.fwd_hit), 32'd0);
        chk("rst_fdata", bus.fwd_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.st_valid = vecs[i].st_valid;
            bus.st_addr  = vecs[i].st_addr;
            bus.st_data  = vecs[i].st_data;
            bus.ld_valid = vecs[i].ld_valid;
            bus.ld_addr  = vecs[i].ld_addr;
            bus.mem_ack  = vecs[i].mem_ack;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.st_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_hit", i), 32'(bus.fwd_hit), 32'(vecs[i].e_hit));
            chk($sformatf("v%0d_fdata", i), bus.fwd_data, vecs[i].e_fdata);
            chk($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_count", i), 32'(bus.count), vecs[i].e_count);
            chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e_empty));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_maddr", i), bus.mem_addr, vecs[i].e_maddr);
                chk($sformatf("v%0d_mdata", i), bus.mem_data, vecs[i].e_mdata);
            end
            tick();
        end
        idle_inputs();

        // Single store, acknowledged six cycles after the request appears.
        push(32'h10, 32'h5);
        chk("single_req_early", 32'(bus.mem_req), 32'd0);
        chk("single_count", 32'(bus.count), 32'd1);
        tick();
        chk("single_req", 32'(bus.mem_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("single_hold%0d_req", i), 32'(bus.mem_req), 32'd1);
            chk($sformatf("single_hold%0d_addr", i), bus.mem_addr, 32'h10);
            chk($sformatf("single_hold%0d_data", i), bus.mem_data, 32'h5);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("single_count_after", 32'(bus.count), 32'd0);
        chk("single_empty_after", 32'(bus.empty), 32'd1);
        chk("single_req_after", 32'(bus.mem_req), 32'd0);

        // Fill, overflow attempt, full push racing an ack, then ordered drain.
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1));
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.st_ready), 32'd0);
        push(32'h200, 32'h99);
        chk("full_ignored_count", 32'(bus.count), 32'd4);
        chk("full_head_addr", bus.mem_addr, 32'h100);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h300;
        bus.st_data  = 32'h77;
        bus.mem_ack  = 1'b1;
        #1;
        chk("race_ready", 32'(bus.st_ready), 32'd0);
        tick();
        idle_inputs();
        chk("race_count", 32'(bus.count), 32'd3);
        chk("race_ready_after", 32'(bus.st_ready), 32'd1);
        drain_one("order_b", 32'h104, 32'h22);
        drain_one("order_c", 32'h108, 32'h33);
        drain_one("order_d", 32'h10C, 32'h44);
        tick();
        tick();
        chk("order_count", 32'(bus.count), 32'd0);
        chk("order_req", 32'(bus.mem_req), 32'd0);

        // Ten simultaneous push/pop pairs walk both pointers around the ring.
        push(32'h400, 32'hA0);
        for (int i = 1; i <= 10; i++) begin
            wait_req($sformatf("wrap%0d", i), ok);
            if (ok) begin
                chk($sformatf("wrap%0d_addr", i), bus.mem_addr, 32'h400 + 32'(4 * (i - 1)));
                chk($sformatf("wrap%0d_data", i), bus.mem_data, 32'hA0 + 32'(i - 1));
                bus.mem_ack  = 1'b1;
                bus.st_valid = 1'b1;
                bus.st_addr  = 32'h400 + 32'(4 * i);
                bus.st_data  = 32'hA0 + 32'(i);
                tick();
                idle_inputs();
                chk($sformatf("wrap%0d_count", i), 32'(bus.count), 32'd1);
            end
        end
        drain_one("wrap_last", 32'h428, 32'hAA);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Reset while a three-entry drain is in flight; a late ack must do nothing.
        push(32'h500, 32'h1);
        push(32'h504, 32'h2);
        push(32'h508, 32'h3);
        chk("mid_req", 32'(bus.mem_req), 32'd1);
        chk("mid_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ack  = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h500;
        #1;
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_ready", 32'(bus.st_ready), 32'd1);
        chk("mid_rst_hit", 32'(bus.fwd_hit), 32'd0);
        chk("mid_rst_fdata", bus.fwd_data, 32'd0);
        tick();
        idle_inputs();
        chk("late_ack_count", 32'(bus.count), 32'd0);
        chk("late_ack_req", 32'(bus.mem_req), 32'd0);
        tick();
        chk("late_ack_req2", 32'(bus.mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of store entries (power of two, at least 2).
REQ-002 The block SHALL have parameter AW, default 32, meaning the address and data width.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port st_valid, input, 1 bit: the MA-stage store request.
REQ-006 The block SHALL have port st_addr, input, AW bits: the store byte address.
REQ-007 The block SHALL have port st_data, input, AW bits: the store word.
REQ-008 The block SHALL have port st_ready, output, 1 bit: the buffer accepts a store this cycle.
REQ-009 The block SHALL have port ld_valid, input, 1 bit: the MA-stage load lookup.
REQ-010 The block SHALL have port ld_addr, input, AW bits: the load byte address.
REQ-011 The block SHALL have port fwd_hit, output, 1 bit: a buffered store matches ld_addr.
REQ-012 The block SHALL have port fwd_data, output, AW bits: data of the youngest matching entry.
REQ-013 The block SHALL have port mem_req, output, 1 bit: main-memory write request.
REQ-014 The block SHALL have ports mem_addr and mem_data, output, AW bits each: the head entry.
REQ-015 The block SHALL have port mem_ack, input, 1 bit: main memory has completed the write.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.
REQ-017 The block SHALL have port empty, output, 1 bit: count == 0.

Function
REQ-018 Storage SHALL be a circular FIFO with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-019 st_ready SHALL equal (registered count < DEPTH); a pop in the same cycle SHALL NOT free a slot for a push.
REQ-020 Push SHALL occur on (st_valid && st_ready): entry[wr_ptr] <= {st_addr, st_data}, wr_ptr+1.
REQ-021 st_valid while !st_ready SHALL be ignored; the store is held upstream by the pipeline stall.
REQ-022 The drain FSM SHALL have states IDLE and REQ: IDLE -> REQ when count != 0; REQ -> IDLE on mem_ack.
REQ-023 mem_req SHALL be 1 exactly in REQ; mem_addr/mem_data SHALL equal entry[rd_ptr] and stay stable while mem_req = 1.
REQ-024 On (REQ && mem_ack) the head SHALL pop (rd_ptr+1); mem_ack outside REQ SHALL be ignored.
REQ-025 A push into an empty buffer SHALL raise mem_req on the following cycle (1-cycle latency); consecutive drains SHALL have one IDLE cycle between them.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push only SHALL add 1; pop only SHALL subtract 1.
REQ-027 Forwarding SHALL be combinational: compare ld_addr[AW-1:2] against every occupied entry, including the head in flight.
REQ-028 When multiple entries match, the entry closest to wr_ptr (the youngest) SHALL win.
REQ-029 A push in the same cycle SHALL NOT be visible to forwarding.
REQ-030 fwd_hit SHALL be 0 when ld_valid = 0 or no entry matches; fwd_data SHALL be 0 when fwd_hit = 0.
REQ-031 Stores SHALL retire to memory in strict program order; same-address stores SHALL NOT be coalesced.

Reset
REQ-032 On RST = 1 at a rising edge the block SHALL set:
- wr_ptr = rd_ptr = count = 0, FSM = IDLE.
- st_ready = 1, empty = 1, mem_req = 0, fwd_hit = 0, fwd_data = 0.
REQ-033 Reset mid-drain SHALL discard all entries; mem_req SHALL be 0 from the cycle after the reset edge, and mem_ack in that cycle SHALL be ignored.
REQ-034 Entry contents SHALL need no reset; no output SHALL depend on unoccupied entries.

Structure
REQ-035 Package wb_pkg SHALL hold DEPTH default, the state encoding (IDLE = 0, REQ = 1) and the word-address slice width.
REQ-036 The youngest-match priority search SHALL be a sub-module wb_fwd_match (combinational; inputs are occupancy mask, entries and rd/wr pointers).
REQ-037 The FIFO and FSM SHALL reside in write_buffer; target is 150-300 RTL lines.

Verification
REQ-038 Single store addr = 0x10, data = 5, mem_ack 6 cycles after mem_req -> mem_req rises 1 cycle after push, mem_addr = 0x10, mem_data = 5, count 1 -> 0 on ack, empty = 1.
REQ-039 Four pushes with mem_ack held 0 -> count = 4, st_ready = 0; fifth st_valid is ignored; one ack -> st_ready = 1 next cycle.
REQ-040 Pushes 0x20 = 7 then 0x20 = 9, then ld 0x22 -> fwd_hit = 1, fwd_data = 9; ld 0x24 -> fwd_hit = 0, fwd_data = 0.
REQ-041 Full buffer with push and ack in the same cycle -> push rejected, count = 3; pointers wrap correctly across 10 push/pop pairs.
REQ-042 RST asserted while in REQ with count = 3 -> next cycle mem_req = 0, count = 0; late mem_ack is ignored.
REQ-043 Drain order check: stores A, B, C retire to memory in the order A, B, C with no duplicates or losses.
